// File: rtl/veggie_rd_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// veggie_rd_arbiter_pkg
//   Shared types and default configuration for the vector register file
//   (veggie) read-port arbiter.
//
//   vreg_t    : one vector register worth of data
//   rd_tag_t  : in-flight read tag {valid, requester id} for the default
//               requester count
//   id_width  : width of a requester id for a given requester count
// ---------------------------------------------------------------------------
package veggie_rd_arbiter_pkg;

    localparam int VREG_W            = 64;
    localparam int VEGGIE_NUM_RD_REQ = 4;
    localparam int VEGGIE_READ_LAT   = 2;
    localparam int VEGGIE_IDX_W      = 5;

    typedef logic [VREG_W-1:0] vreg_t;

    // A single requester still needs a 1-bit id so the tag type stays legal.
    function automatic int id_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    localparam int RD_ID_W = id_width(VEGGIE_NUM_RD_REQ);

    typedef struct packed {
        logic               valid;
        logic [RD_ID_W-1:0] id;
    } rd_tag_t;

endpackage

// File: rtl/veggie_rd_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin pick. Scans req_i starting at ptr_i
//   (wrapping modulo NUM_REQ) and grants the first set bit.
//
//   req_i        in   NUM_REQ  eligible requesters
//   ptr_i        in   ID_W     highest-priority index this cycle
//   gnt_o        out  NUM_REQ  one-hot grant (all zero when nothing granted)
//   gnt_valid_o  out  1        a grant was made
//   gnt_id_o     out  ID_W     index of the granted requester (0 when none)
// ---------------------------------------------------------------------------
module rr_arbiter
    import veggie_rd_arbiter_pkg::*;
#(
    parameter int NUM_REQ = VEGGIE_NUM_RD_REQ,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic               gnt_valid_o,
    output logic [ID_W-1:0]    gnt_id_o
);

    always_comb begin
        int idx;
        // NOTE: every output gets a default before any conditional write so
        // no path leaves a value unassigned and no latch is inferred.
        gnt_o       = '0;
        gnt_valid_o = 1'b0;
        gnt_id_o    = '0;
        idx         = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = (int'(ptr_i) + off) % NUM_REQ;
            if (!gnt_valid_o && req_i[idx]) begin
                gnt_valid_o = 1'b1;
                gnt_id_o    = ID_W'(idx);
            end
        end
        gnt_o[gnt_id_o] = gnt_valid_o;
    end

endmodule

// File: rtl/veggie_rd_arbiter.sv
// ---------------------------------------------------------------------------
// veggie_rd_arbiter
//   Round-robin arbiter and sequencer for the veggie read port. Grants at
//   most one read per cycle, holds back reads that collide with a same-cycle
//   write, tracks in-flight reads through the fixed read latency and steers
//   each returned vector to the requester that issued it.
//
//   CLK        in   1                 rising-edge clock
//   RST        in   1                 synchronous active-high reset
//   req_valid  in   NUM_REQ           per-requester read request
//   req_sel    in   NUM_REQ x IDX_W   register index per requester
//   req_ready  out  NUM_REQ           one-hot grant (same cycle)
//   flush      in   1                 drop all in-flight reads
//   wr_en      in   1                 snooped writeback enable
//   wr_sel     in   IDX_W             snooped writeback register
//   vg_ren     out  1                 veggie read enable
//   vg_rsel    out  IDX_W             veggie read index (0 when idle)
//   vg_rdata   in   vreg_t            veggie data, READ_LAT after vg_ren
//   rsp_valid  out  NUM_REQ           one-hot response strobe
//   rsp_data   out  vreg_t            response data, broadcast
// ---------------------------------------------------------------------------
module veggie_rd_arbiter
    import veggie_rd_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = VEGGIE_NUM_RD_REQ,
    parameter int READ_LAT = VEGGIE_READ_LAT,
    parameter int IDX_W    = VEGGIE_IDX_W
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0][IDX_W-1:0]  req_sel,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic                           flush,
    input  logic                           wr_en,
    input  logic [IDX_W-1:0]               wr_sel,
    output logic                           vg_ren,
    output logic [IDX_W-1:0]               vg_rsel,
    input  vreg_t                          vg_rdata,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output vreg_t                          rsp_data
);

    localparam int ID_W = id_width(NUM_REQ);

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] gnt;
    logic               gnt_valid;
    logic [ID_W-1:0]    gnt_id;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    tag_t               tag_d;
    tag_t               tag_q [READ_LAT];

    // A request whose register is being written this cycle would read stale
    // data; it stays pending and competes again next cycle. Reset masks every
    // request so nothing reaches the veggie while RST is high.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid[i] && !RST &&
                          !(wr_en && (wr_sel == req_sel[i]));
        end
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req_i       (eligible),
        .ptr_i       (ptr_q),
        .gnt_o       (gnt),
        .gnt_valid_o (gnt_valid),
        .gnt_id_o    (gnt_id)
    );

    assign req_ready = gnt;
    assign vg_ren    = gnt_valid;
    assign vg_rsel   = gnt_valid ? req_sel[gnt_id] : '0;

    // Priority moves to the requester after the one just served; flush does
    // not disturb fairness.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt_valid) begin
            ptr_d = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
        end
    end

    // A grant in the flush cycle still reads the veggie but never responds.
    always_comb begin
        tag_d.valid = gnt_valid && !flush;
        tag_d.id    = gnt_id;
    end

    // NOTE: state updates use non-blocking assignments so every stage of the
    // tag pipe samples the previous stage's old value on the same edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_q <= '0;
            // NOTE: only the valid bits carry meaning, but the pipe is just a
            // few flops, so clearing whole entries keeps ids deterministic.
            for (int s = 0; s < READ_LAT; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            ptr_q    <= ptr_d;
            tag_q[0] <= tag_d;
            for (int s = 1; s < READ_LAT; s++) begin
                tag_q[s] <= flush ? tag_t'('0) : tag_q[s-1];
            end
        end
    end

    // A response completing in a reset cycle belongs to a discarded read.
    always_comb begin
        rsp_valid = '0;
        if (tag_q[READ_LAT-1].valid && !RST) begin
            rsp_valid[tag_q[READ_LAT-1].id] = 1'b1;
        end
    end

    assign rsp_data = vg_rdata;

endmodule
